jt10_adpcm_div_arb: RTL and testbench

//  Round-robin arbiter/sequencer sharing one jt10_adpcm_div (serial restoring divider, DW cen-cycles/op)

---
 rtl/jt10_adpcm_div_arb_if.sv | 26 ++
 rtl/jt10_adpcm_div_arb.sv | 124 ++++++++++++
 tb/tb_jt10_adpcm_div_arb.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/jt10_adpcm_div_arb_if.sv
// Requester-side bus of the shared ADPCM divider arbiter.
// The master modport belongs to the channel logic and the slave modport to the arbiter.
interface jt10_adpcm_div_arb_if #(
    parameter int DW = 16,
    parameter int N  = 4,
    parameter int IW = 2
);
    logic [N-1:0]    req;
    logic [N*DW-1:0] a_bus;
    logic [N*DW-1:0] b_bus;
    logic [N-1:0]    ack;
    logic [DW-1:0]   q_d;
    logic [DW-1:0]   q_r;
    logic [IW-1:0]   gnt_id;
    logic            busy;

    modport master (
        output req, a_bus, b_bus,
        input  ack, q_d, q_r, gnt_id, busy
    );

    modport slave (
        input  req, a_bus, b_bus,
        output ack, q_d, q_r, gnt_id, busy
    );
endinterface

// File: rtl/jt10_adpcm_div_arb.sv
// Round-robin sequencer that shares one serial divider between N ADPCM requesters.
// A zero divisor skips the divider and returns all-ones with the dividend as the remainder.
module jt10_adpcm_div_arb #(
    parameter int DW = 16,
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cen,
    jt10_adpcm_div_arb_if.slave  bus,
    output logic                 div_start,
    output logic [DW-1:0]        div_a,
    output logic [DW-1:0]        div_b,
    input  logic [DW-1:0]        div_d,
    input  logic [DW-1:0]        div_r,
    input  logic                 div_working
);
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] LAUNCH = 2'd1;
    localparam logic [1:0] RUN    = 2'd2;
    localparam logic [1:0] DONE   = 2'd3;

    localparam logic [N-1:0] ACK_ONE = N'(1);

    logic [1:0]    state_reg;
    logic [IW-1:0] ptr_reg;
    logic [IW-1:0] gnt_reg;
    logic [N-1:0]  ack_reg;
    logic [DW-1:0] q_d_reg;
    logic [DW-1:0] q_r_reg;
    logic [DW-1:0] div_a_reg;
    logic [DW-1:0] div_b_reg;

    logic [DW-1:0] a_arr [N];
    logic [DW-1:0] b_arr [N];

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_unpack
            assign a_arr[gi] = bus.a_bus[gi*DW +: DW];
            assign b_arr[gi] = bus.b_bus[gi*DW +: DW];
        end
    endgenerate

    // Search starts just after the last winner, so the most recent owner has lowest priority.
    logic          win_found;
    logic [IW-1:0] win_id;
    int            idx;

    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        idx       = 0;
        for (int k = 1; k <= N; k++) begin
            idx = (int'(ptr_reg) + k) % N;
            if (!win_found && bus.req[idx]) begin
                win_found = 1'b1;
                win_id    = IW'(idx);
            end
        end
    end

    logic [DW-1:0] win_a;
    logic [DW-1:0] win_b;

    assign win_a = a_arr[win_id];
    assign win_b = b_arr[win_id];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            ptr_reg   <= IW'(N - 1);
            gnt_reg   <= '0;
            ack_reg   <= '0;
            q_d_reg   <= '0;
            q_r_reg   <= '0;
            div_a_reg <= '0;
            div_b_reg <= '0;
        end else if (cen) begin
            case (state_reg)
                IDLE: begin
                    if (win_found) begin
                        gnt_reg   <= win_id;
                        ptr_reg   <= win_id;
                        div_a_reg <= win_a;
                        div_b_reg <= win_b;
                        if (win_b == '0) begin
                            state_reg <= DONE;
                            q_d_reg   <= '1;
                            q_r_reg   <= win_a;
                            ack_reg   <= ACK_ONE << win_id;
                        end else begin
                            state_reg <= LAUNCH;
                        end
                    end
                end
                LAUNCH: state_reg <= RUN;
                RUN: begin
                    // The divider raises working on the launch edge, so the first RUN sample is valid.
                    if (!div_working) begin
                        state_reg <= DONE;
                        q_d_reg   <= div_d;
                        q_r_reg   <= div_r;
                        ack_reg   <= ACK_ONE << gnt_reg;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    ack_reg   <= '0;
                end
            endcase
        end
    end

    assign div_start  = (state_reg == LAUNCH);
    assign div_a      = div_a_reg;
    assign div_b      = div_b_reg;
    assign bus.ack    = ack_reg;
    assign bus.q_d    = q_d_reg;
    assign bus.q_r    = q_r_reg;
    assign bus.gnt_id = gnt_reg;
    assign bus.busy   = (state_reg != IDLE);
endmodule

// File: tb/tb_jt10_adpcm_div_arb.sv
// Bench for jt10_adpcm_div_arb with a cycle-accurate stand-in for the serial divider.
// Covers single operations, the zero-divisor bypass, round-robin order, clock-enable gating and reset mid-run.
module tb_jt10_adpcm_div_arb;
    localparam int DW = 16;
    localparam int N  = 4;
    localparam int IW = 2;

    logic clk = 1'b0;
    logic rst_n;
    logic cen;
    logic div_start, div_working;
    logic [DW-1:0] div_a, div_b, div_d, div_r;

    int total = 0;
    int bad   = 0;

    jt10_adpcm_div_arb_if #(.DW(DW), .N(N), .IW(IW)) bus ();

    jt10_adpcm_div_arb #(.DW(DW), .N(N), .IW(IW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cen        (cen),
        .bus        (bus),
        .div_start  (div_start),
        .div_a      (div_a),
        .div_b      (div_b),
        .div_d      (div_d),
        .div_r      (div_r),
        .div_working(div_working)
    );

    always #5 clk = ~clk;

    // Divider stand-in: busy for DW cen edges after the launch edge, result only visible at the end.
    int            dcnt;
    logic [DW-1:0] ra, rb;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_working <= 1'b0;
            dcnt        <= 0;
            div_d       <= '0;
            div_r       <= '0;
            ra          <= '0;
            rb          <= '0;
        end else if (cen) begin
            if (div_start) begin
                div_working <= 1'b1;
                dcnt        <= 0;
                ra          <= div_a;
                rb          <= div_b;
                div_d       <= 16'hDEAD;
                div_r       <= 16'hBEEF;
            end else if (div_working) begin
                if (dcnt == DW - 1) begin
                    div_working <= 1'b0;
                    div_d       <= ra / rb;
                    div_r       <= ra % rb;
                end else begin
                    dcnt <= dcnt + 1;
                end
            end
        end
    end

    // cen is updated shortly after each rising edge, so at the falling edge it shows the next edge's value.
    bit cen_mode = 1'b0;
    int ph = 0;
    always @(posedge clk) begin
        #2;
        if (cen_mode) begin
            ph  = (ph + 1) % 3;
            cen = (ph == 0);
        end else begin
            cen = 1'b1;
        end
    end

    // Output-hold monitor for edges with cen low.
    localparam int SW = 4*DW + 2*N + IW + 2;
    bit          mon_en = 1'b0;
    bit          snap_valid = 1'b0;
    logic [SW-1:0] snap, cur;
    int          stab_bad = 0;
    always @(negedge clk) begin
        cur = {bus.ack, bus.req, bus.q_d, bus.q_r, bus.gnt_id, bus.busy, div_a, div_b, div_start};
        if (mon_en && snap_valid && (snap[SW-1:0] != cur))
            stab_bad++;
        snap       = cur;
        snap_valid = mon_en && !cen;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [N-1:0] onehot(input int id);
        logic [N-1:0] v;
        v = '0;
        v[id] = 1'b1;
        return v;
    endfunction

    task automatic run_op(input int id, input logic [DW-1:0] a, input logic [DW-1:0] b,
                          input logic [DW-1:0] eq, input logic [DW-1:0] er,
                          input int exp_lat, input int exp_alen, input int exp_starts);
        int t, lat, starts, alen;
        @(negedge clk);
        bus.a_bus[id*DW +: DW] = a;
        bus.b_bus[id*DW +: DW] = b;
        bus.req[id] = 1'b1;
        starts = 0;
        t = 0;
        do begin
            @(negedge clk);
            t++;
            if (div_start && cen) starts++;
        end while (!bus.busy && t < 40);
        if (!bus.busy) begin
            chk("grant_timeout", 64'(t), 64'(0));
            bus.req[id] = 1'b0;
            return;
        end
        lat = 0;
        while (bus.ack == '0 && lat < 400) begin
            @(negedge clk);
            lat++;
            if (div_start && cen) starts++;
        end
        chk("ack_onehot", 64'(bus.ack), 64'(onehot(id)));
        chk("q_d", 64'(bus.q_d), 64'(eq));
        chk("q_r", 64'(bus.q_r), 64'(er));
        chk("gnt_id", 64'(bus.gnt_id), 64'(id));
        chk("div_a", 64'(div_a), 64'(a));
        chk("div_b", 64'(div_b), 64'(b));
        chk("latency", 64'(lat), 64'(exp_lat));
        chk("starts", 64'(starts), 64'(exp_starts));
        bus.req[id] = 1'b0;
        alen = 1;
        while (bus.ack != '0 && alen < 20) begin
            @(negedge clk);
            if (bus.ack != '0) alen++;
        end
        chk("ack_len", 64'(alen), 64'(exp_alen));
        chk("idle_after", 64'(bus.busy), 64'(0));
        $display("op id=%0d a=%h b=%h q_d=%h q_r=%h lat=%0d ack_len=%0d",
                 id, a, b, bus.q_d, bus.q_r, lat, alen);
    endtask

    typedef struct {
        int            id;
        logic [DW-1:0] a, b, q, r;
        int            lat;
        int            starts;
    } vec_t;

    vec_t vecs [6];

    initial begin
        int t, extra;
        logic [N-1:0] ack_seen;

        vecs[0] = '{id: 0, a: 16'd100,   b: 16'd7,  q: 16'd14,    r: 16'd2,    lat: DW + 2, starts: 1};
        vecs[1] = '{id: 2, a: 16'h1234,  b: 16'd0,  q: 16'hFFFF,  r: 16'h1234, lat: 0,      starts: 0};
        vecs[2] = '{id: 3, a: 16'd1000,  b: 16'd10, q: 16'd100,   r: 16'd0,    lat: DW + 2, starts: 1};
        vecs[3] = '{id: 1, a: 16'd5,     b: 16'd9,  q: 16'd0,     r: 16'd5,    lat: DW + 2, starts: 1};
        vecs[4] = '{id: 1, a: 16'd65535, b: 16'd1,  q: 16'd65535, r: 16'd0,    lat: DW + 2, starts: 1};
        vecs[5] = '{id: 0, a: 16'd0,     b: 16'd0,  q: 16'hFFFF,  r: 16'd0,    lat: 0,      starts: 0};

        rst_n     = 1'b0;
        cen       = 1'b1;
        bus.req   = '0;
        bus.a_bus = '0;
        bus.b_bus = '0;
        repeat (2) @(negedge clk);
        chk("rst_ack", 64'(bus.ack), 64'(0));
        chk("rst_q_d", 64'(bus.q_d), 64'(0));
        chk("rst_q_r", 64'(bus.q_r), 64'(0));
        chk("rst_gnt", 64'(bus.gnt_id), 64'(0));
        chk("rst_busy", 64'(bus.busy), 64'(0));
        chk("rst_div_ab", 64'({div_a, div_b}), 64'(0));
        chk("rst_start", 64'(div_start), 64'(0));
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_busy", 64'(bus.busy), 64'(0));

        for (int i = 0; i < 6; i++)
            run_op(vecs[i].id, vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r,
                   vecs[i].lat, 1, vecs[i].starts);

        // Clock enable high one cycle in three: timing scales by three, results unchanged.
        cen_mode = 1'b1;
        mon_en   = 1'b1;
        run_op(3, 16'd65535, 16'd255, 16'd257, 16'd0, 3*(DW + 2), 3, 1);
        mon_en   = 1'b0;
        cen_mode = 1'b0;
        chk("cen_hold", 64'(stab_bad), 64'(0));
        repeat (3) @(negedge clk);

        // Asynchronous reset in the middle of a running division.
        @(negedge clk);
        bus.a_bus[0 +: DW] = 16'd100;
        bus.b_bus[0 +: DW] = 16'd7;
        bus.req = 4'b0001;
        t = 0;
        while (!div_start && t < 20) begin
            @(negedge clk);
            t++;
        end
        chk("rst_run_start", 64'(div_start), 64'(1));
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy", 64'(bus.busy), 64'(0));
        chk("arst_ack", 64'(bus.ack), 64'(0));
        chk("arst_start", 64'(div_start), 64'(0));
        bus.req = '0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("arst_gnt", 64'(bus.gnt_id), 64'(0));
        run_op(1, 16'd77, 16'd7, 16'd11, 16'd0, DW + 2, 1, 1);

        // Round-robin with all four requesting, each re-raising after its ack.
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < N; i++) begin
            bus.a_bus[i*DW +: DW] = DW'(50 + i);
            bus.b_bus[i*DW +: DW] = 16'd3;
        end
        bus.req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            int exp_id;
            logic [DW-1:0] eq, er;
            exp_id = k % N;
            eq = (exp_id == 0) ? 16'd16 : 16'd17;
            er = (exp_id == 0) ? 16'd2 : (exp_id == 1) ? 16'd0 : (exp_id == 2) ? 16'd1 : 16'd2;
            t = 0;
            while (bus.ack == '0 && t < 100) begin
                @(negedge clk);
                t++;
            end
            ack_seen = bus.ack;
            chk("rr_ack", 64'(ack_seen), 64'(onehot(exp_id)));
            chk("rr_gnt", 64'(bus.gnt_id), 64'(exp_id));
            chk("rr_q_d", 64'(bus.q_d), 64'(eq));
            chk("rr_q_r", 64'(bus.q_r), 64'(er));
            $display("rr op=%0d gnt=%0d ack=%b q_d=%0d q_r=%0d", k, bus.gnt_id, ack_seen, bus.q_d, bus.q_r);
            bus.req[exp_id] = 1'b0;
            @(negedge clk);
            chk("rr_single_ack", 64'(bus.ack), 64'(0));
            bus.req[exp_id] = 1'b1;
        end
        bus.req = '0;
        t = 0;
        while (bus.busy && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk("rr_drain", 64'(bus.busy), 64'(0));

        // Operands changed and request dropped while the divider is running.
        @(negedge clk);
        bus.a_bus[1*DW +: DW] = 16'd200;
        bus.b_bus[1*DW +: DW] = 16'd9;
        bus.req = 4'b0010;
        repeat (6) @(negedge clk);
        bus.a_bus[1*DW +: DW] = 16'd999;
        bus.b_bus[1*DW +: DW] = 16'd1;
        bus.req = '0;
        t = 0;
        while (bus.ack == '0 && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk("drop_ack", 64'(bus.ack), 64'(4'b0010));
        chk("drop_q_d", 64'(bus.q_d), 64'(22));
        chk("drop_q_r", 64'(bus.q_r), 64'(2));
        $display("drop op ack=%b q_d=%0d q_r=%0d", bus.ack, bus.q_d, bus.q_r);
        @(negedge clk);
        chk("drop_ack_clear", 64'(bus.ack), 64'(0));
        extra = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.ack != '0 || bus.busy) extra++;
        end
        chk("drop_no_regrant", 64'(extra), 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
